vga_timing_counter: RTL and testbench
=====================================

Name: vga_timing_counter

Overview:
Free-running VGA raster counter that produces the hcount/vcount pair consumed by the horizontal and vertical sync generators and the pixel renderer. It derives a pixel-rate enable from the board clock and wraps the counters at line and frame boundaries. It also emits line/frame strobes, an active-video flag and a frame counter, which the game logic uses for cursor blinking and board updates.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, total pixels per line (active + porches + pulse)
V_ACTIVE, 480, visible lines per frame
V_TOTAL, 525, total lines per frame
PIX_DIV, 2, board clocks per pixel (used only with VGA_PIXEL_DIV_EN); legal range 2..16

Ports:
clk  in  1  board clock
rst  in  1  synchronous, active-high reset
pix_en  out  1  pixel-rate enable; counters advance only on clocks where it is high
hcount  out  10  horizontal pixel position, 0..H_TOTAL-1
vcount  out  10  vertical line position, 0..V_TOTAL-1
active  out  1  high when hcount < H_ACTIVE and vcount < V_ACTIVE
line_end  out  1  one-clk strobe: pix_en high and hcount == H_TOTAL-1
frame_end  out  1  one-clk strobe: line_end high and vcount == V_TOTAL-1
frame_cnt  out  8  completed-frame counter, wraps 255->0

Behaviour:
- Reset is synchronous and active-high, and takes priority over everything else.
- Values on the clock where rst is sampled high: hcount=0, vcount=0, frame_cnt=0, divider count=0.
- While rst is high: pix_en=0, line_end=0, frame_end=0. active=1, decoded from the zeroed counters.
- Divider: div_cnt counts 0..PIX_DIV-1 and wraps. pix_en = (div_cnt == PIX_DIV-1), decoded combinationally from the register.
- First pix_en after reset release: PIX_DIV-1 clocks after the first clock with rst low.
- hcount on a clock with pix_en high:
  - hcount < H_TOTAL-1: hcount += 1.
  - hcount == H_TOTAL-1: hcount <= 0 and vcount advances.
- vcount advance:
  - vcount < V_TOTAL-1: vcount += 1.
  - vcount == V_TOTAL-1: vcount <= 0 and frame_cnt += 1 (mod 256).
- On clocks with pix_en low, all counters hold.
- active, line_end and frame_end are combinational decodes of the registered counters plus pix_en, so they have zero latency relative to hcount/vcount.
- line_end and frame_end are high for exactly one clk per line/frame. At the frame wrap both are high on the same clk.
- hcount/vcount never take values >= H_TOTAL/V_TOTAL. Comparisons use 10-bit unsigned arithmetic; the parameters must fit in 10 bits.
- Reset mid-line or mid-frame: counters return to 0 on the next clk. No strobe is emitted for the aborted line/frame.
- All outputs are glitch-tolerant only within clk; downstream sync blocks register them.

Optional Feature:
VGA_PIXEL_DIV_EN
- Defined: the divider is instantiated and pix_en pulses once every PIX_DIV clocks, for a 50 MHz board clock driving a 25 MHz pixel rate.
- Undefined: the divider is removed and pix_en is tied to 1 (also 1 during reset), so counters advance every clk. clk is then the pixel clock and PIX_DIV is ignored.

Decomposition:
- Shared package vga_pkg holds:
  - H_ACTIVE, H_FRONT_PORCH (16), H_PULSE (96), H_TOTAL
  - V_ACTIVE, V_FRONT_PORCH (10), V_PULSE (2), V_TOTAL
  - the 10-bit coord_t typedef
- The sync generators and the renderer import the same package.
- One sub-module: pixel_clock_divider (clk, rst -> pix_en). It is compiled only under VGA_PIXEL_DIV_EN.

Test Plan:
1. Reset release, PIX_DIV=2, macro defined -> pix_en toggles 0,1,0,1; hcount=1 after the 2nd clk; vcount=0; frame_cnt=0.
2. Run to hcount=799, vcount=0 -> on the pix_en clk line_end=1 for one clk; next hcount=0, vcount=1; frame_end=0.
3. Run to hcount=799, vcount=524 -> line_end=frame_end=1 on the same clk; next hcount=0, vcount=0, frame_cnt 0->1.
4. Active boundaries: (639,0) active=1; (640,0) active=0; (0,479) active=1; (0,480) active=0.
5. Assert rst for 1 clk at hcount=400, vcount=200 -> next clk hcount=0, vcount=0, frame_cnt=0, pix_en=0; no line_end emitted.
6. Preload 255 frames (or force frame_cnt=255), then complete a frame -> frame_cnt=0. Repeat with the macro undefined: hcount increments every clk and pix_en is constantly 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 raster geometry and the coordinate type used by the
// timing counter, the sync generators and the pixel renderer.
package vga_pkg;

    localparam int H_ACTIVE      = 640;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_PULSE       = 96;
    localparam int H_TOTAL       = 800;

    localparam int V_ACTIVE      = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_PULSE       = 2;
    localparam int V_TOTAL       = 525;

    localparam int PIX_DIV       = 2;
    localparam int COORD_W       = 10;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_counter_pixel_clock_divider.sv
// Pixel-rate enable generator: one pix_en pulse every PIX_DIV board clocks.
// Only compiled into the design when VGA_PIXEL_DIV_EN is defined.
module pixel_clock_divider #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);

    localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

    logic [3:0] div_cnt;

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    assign pix_en = !rst && (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_counter.sv
// Free-running VGA raster counter with line/frame strobes and a frame counter.
// Define VGA_PIXEL_DIV_EN to derive the pixel enable from the board clock.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_TOTAL  = vga_pkg::V_TOTAL,
    parameter int PIX_DIV  = vga_pkg::PIX_DIV
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       active,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_cnt
);

    // Elaboration-time guard on the geometry and divider range.
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W) ||
        H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL ||
        PIX_DIV < 2 || PIX_DIV > 16) begin : g_bad_params
        $error("vga_timing_counter: illegal geometry or PIX_DIV");
    end

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT  = coord_t'(V_ACTIVE);

`ifdef VGA_PIXEL_DIV_EN
    pixel_clock_divider #(
        .PIX_DIV (PIX_DIV)
    ) u_pixel_clock_divider (
        .clk    (clk),
        .rst    (rst),
        .pix_en (pix_en)
    );
`else
    // clk is already the pixel clock.
    assign pix_en = 1'b1;
`endif

    coord_t h_q;
    coord_t v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q       <= '0;
            v_q       <= '0;
            frame_cnt <= '0;
        end else if (pix_en) begin
            if (h_q >= H_LAST) begin
                h_q <= '0;
                if (v_q >= V_LAST) begin
                    v_q       <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    v_q <= v_q + coord_t'(1);
                end
            end else begin
                h_q <= h_q + coord_t'(1);
            end
        end
    end

    assign hcount = h_q;
    assign vcount = v_q;

    // Decodes are zero-latency against the counters; strobes are muted in reset.
    assign active    = (h_q < H_ACT) && (v_q < V_ACT);
    assign line_end  = !rst && pix_en && (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_counter.sv
// Directed bench for vga_timing_counter: a full-size instance for line timing
// and a shrunken-raster instance for frame wrap and frame counter rollover.
module tb_vga_timing_counter;

`ifdef VGA_PIXEL_DIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    // Shrunken raster so whole frames fit in a short run.
    localparam int SH_A = 6;
    localparam int SH_T = 8;
    localparam int SV_A = 4;
    localparam int SV_T = 5;
    localparam int S_FRAME = SH_T * SV_T;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       b_pe, b_act, b_le, b_fe;
    logic [9:0] b_h, b_v;
    logic [7:0] b_fc;
    logic       s_pe, s_act, s_le, s_fe;
    logic [9:0] s_h, s_v;
    logic [7:0] s_fc;

    int n_vec = 0;
    int n_err = 0;
    int n     = 0;   // clock edges sampled with rst low since last release

    always #5 clk = ~clk;

    vga_timing_counter #(
        .PIX_DIV (2)
    ) dut_big (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (b_pe),
        .hcount    (b_h),
        .vcount    (b_v),
        .active    (b_act),
        .line_end  (b_le),
        .frame_end (b_fe),
        .frame_cnt (b_fc)
    );

    vga_timing_counter #(
        .H_ACTIVE (SH_A),
        .H_TOTAL  (SH_T),
        .V_ACTIVE (SV_A),
        .V_TOTAL  (SV_T),
        .PIX_DIV  (2)
    ) dut_small (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (s_pe),
        .hcount    (s_h),
        .vcount    (s_v),
        .active    (s_act),
        .line_end  (s_le),
        .frame_end (s_fe),
        .frame_cnt (s_fc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    // Expected raster state after n post-reset clocks for a given geometry.
    task automatic check_frame(input string tag, input int ht, input int vt, input int ha, input int va,
                               input logic pe, input logic [9:0] h, input logic [9:0] v,
                               input logic act, input logic le, input logic fe, input logic [7:0] fc);
        int p, eh, ev, ef;
        logic epe, ele;
        p   = n / DIV;
        eh  = p % ht;
        ev  = (p / ht) % vt;
        ef  = (p / (ht * vt)) % 256;
        epe = (n % DIV) == DIV - 1;
        ele = epe && (eh == ht - 1);
        check({tag, ".pix_en"},    32'(pe),  32'(epe));
        check({tag, ".hcount"},    32'(h),   32'(eh));
        check({tag, ".vcount"},    32'(v),   32'(ev));
        check({tag, ".active"},    32'(act), 32'((eh < ha) && (ev < va)));
        check({tag, ".line_end"},  32'(le),  32'(ele));
        check({tag, ".frame_end"}, 32'(fe),  32'(ele && (ev == vt - 1)));
        check({tag, ".frame_cnt"}, 32'(fc),  32'(ef));
    endtask

    task automatic check_reset(input string tag, input logic pe, input logic [9:0] h, input logic [9:0] v,
                               input logic act, input logic le, input logic fe, input logic [7:0] fc);
        check({tag, ".pix_en"},    32'(pe),  32'(DIV == 1));
        check({tag, ".hcount"},    32'(h),   32'd0);
        check({tag, ".vcount"},    32'(v),   32'd0);
        check({tag, ".active"},    32'(act), 32'd1);
        check({tag, ".line_end"},  32'(le),  32'd0);
        check({tag, ".frame_end"}, 32'(fe),  32'd0);
        check({tag, ".frame_cnt"}, 32'(fc),  32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) n++;
        #1;
    endtask

    task automatic check_big(input string tag);
        check_frame(tag, 800, 525, 640, 480, b_pe, b_h, b_v, b_act, b_le, b_fe, b_fc);
    endtask

    task automatic check_small(input string tag);
        check_frame(tag, SH_T, SV_T, SH_A, SV_A, s_pe, s_h, s_v, s_act, s_le, s_fe, s_fc);
    endtask

    // Advance to a given post-reset clock count, tracking the small raster every clock.
    task automatic run_to(input int target);
        while (n < target) begin
            tick();
            check_small("sweep");
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_reset("rst.big", b_pe, b_h, b_v, b_act, b_le, b_fe, b_fc);
        check_reset("rst.small", s_pe, s_h, s_v, s_act, s_le, s_fe, s_fc);

        // Release and first pixel enables
        rst = 1'b0;
        n   = 0;
        check_big("t1.c0");
        check("t1.c0.pix_en", 32'(b_pe), 32'(DIV == 1));
        tick();
        check_big("t1.c1");
        check("t1.c1.pix_en", 32'(b_pe), 32'd1);
        tick();
        check_big("t1.c2");
        check("t1.c2.hcount", 32'(b_h), (DIV == 2) ? 32'd1 : 32'd2);
        check("t1.c2.vcount", 32'(b_v), 32'd0);
        tick();
        check_big("t1.c3");

        // Vertical active boundary and frame wrap on the small raster
        run_to(3 * SH_T * DIV);
        check("s.v3.active", 32'(s_act), 32'd1);
        check("s.v3.vcount", 32'(s_v), 32'd3);
        run_to(4 * SH_T * DIV);
        check("s.v4.active", 32'(s_act), 32'd0);
        check("s.v4.vcount", 32'(s_v), 32'd4);
        run_to((S_FRAME - 1) * DIV + DIV - 1);
        check("s.wrap.hcount", 32'(s_h), 32'(SH_T - 1));
        check("s.wrap.line_end", 32'(s_le), 32'd1);
        check("s.wrap.frame_end", 32'(s_fe), 32'd1);
        tick();
        check("s.next.hcount", 32'(s_h), 32'd0);
        check("s.next.vcount", 32'(s_v), 32'd0);
        check("s.next.frame_cnt", 32'(s_fc), 32'd1);
        check("s.next.frame_end", 32'(s_fe), 32'd0);

        // Horizontal active boundary and line end on the full raster
        run_to(639 * DIV);
        check_big("b.h639");
        check("b.h639.active", 32'(b_act), 32'd1);
        run_to(640 * DIV);
        check_big("b.h640");
        check("b.h640.active", 32'(b_act), 32'd0);
        run_to(799 * DIV + DIV - 1);
        check_big("b.h799");
        check("b.h799.line_end", 32'(b_le), 32'd1);
        check("b.h799.frame_end", 32'(b_fe), 32'd0);
        tick();
        check_big("b.h0v1");
        check("b.h0v1.hcount", 32'(b_h), 32'd0);
        check("b.h0v1.vcount", 32'(b_v), 32'd1);
        check("b.h0v1.line_end", 32'(b_le), 32'd0);

        // Reset mid-line, mid-frame
        run_to((800 + 400) * DIV);
        check("b.mid.hcount", 32'(b_h), 32'd400);
        check("b.mid.vcount", 32'(b_v), 32'd1);
        rst = 1'b1;
        check("b.mid.rst.line_end", 32'(b_le), 32'd0);
        tick();
        check_reset("midrst.big", b_pe, b_h, b_v, b_act, b_le, b_fe, b_fc);
        check_reset("midrst.small", s_pe, s_h, s_v, s_act, s_le, s_fe, s_fc);
        rst = 1'b0;
        n   = 0;
        check_big("midrst.rel");

        // Frame counter rollover 255 -> 0
        run_to(255 * S_FRAME * DIV);
        check("s.fc255", 32'(s_fc), 32'd255);
        run_to(256 * S_FRAME * DIV - 1);
        check("s.roll.frame_end", 32'(s_fe), 32'd1);
        check("s.roll.line_end", 32'(s_le), 32'd1);
        check("s.roll.frame_cnt", 32'(s_fc), 32'd255);
        tick();
        check("s.roll0.frame_cnt", 32'(s_fc), 32'd0);
        check("s.roll0.hcount", 32'(s_h), 32'd0);
        check("s.roll0.vcount", 32'(s_v), 32'd0);
        check_big("final.big");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
